// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: jump-select encodings, fetch FSM states,
// instruction field positions and the branch-offset helper.
package mips_pkg;

    // Controller jump-select encodings; the fourth code is reserved and fetches sequentially.
    localparam logic [1:0] JMP_SEQ = 2'd0;
    localparam logic [1:0] JMP_J   = 2'd1;
    localparam logic [1:0] JMP_JR  = 2'd2;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Instruction field positions.
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned FUNC_MSB = 5;

    // Sign-extended 16-bit branch immediate, scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
// Without PC_MISALIGN_CHECK_EN the low two bits of the target are cleared;
// with it they pass through so the fetch stage can detect misalignment.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] instr_idx_i,
    input  logic [1:0]  jmp_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] target;

    assign pc_plus4_o = pc_i + 32'd4;

    // Target select: the jump kind wins over the branch condition; the reserved code is sequential.
    always_comb begin
        target = pc_plus4_o;
        case (jmp_i)
            JMP_JR:  target = jr_target_i;
            JMP_J:   target = {pc_plus4_o[31:28], instr_idx_i, 2'b00};
            JMP_SEQ: begin
                if (branch_taken_i) begin
                    target = pc_plus4_o + branch_offset(instr_idx_i[15:0]);
                end
            end
            default: target = pc_plus4_o;
        endcase
    end

`ifdef PC_MISALIGN_CHECK_EN
    assign next_pc_o = target;
`else
    assign next_pc_o = {target[31:2], 2'b00};
`endif

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage with FETCH / EXEC / HALT sequencing.
// Optional macro PC_MISALIGN_CHECK_EN: a misaligned next PC sets a sticky
// misalign_err, freezes the offending PC and halts until reset.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [5:0]  opc,
    output logic [5:0]  func,
    output logic [31:0] pc_plus4,
    input  logic        ex_done,
    input  logic [1:0]  jmp,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  next_pc;

    pc_next u_pc_next (
        .pc_i           (pc_q),
        .instr_idx_i    (ir_q[25:0]),
        .jmp_i          (jmp),
        .branch_taken_i (branch_taken),
        .jr_target_i    (jr_target),
        .pc_plus4_o     (pc_plus4),
        .next_pc_o      (next_pc)
    );

`ifdef PC_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // The request is gated by rst_n so it drops the moment reset asserts.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;
    assign ir_valid  = (state_q == EXEC);
    assign ir        = ir_q;
    assign opc       = ir_q[OPC_MSB:OPC_LSB];
    assign func      = ir_q[FUNC_MSB:0];

    // Next-state logic: capture on imem_ready in FETCH, retire on ex_done in EXEC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef PC_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ex_done) begin
                    pc_d = next_pc;
`ifdef PC_MISALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    state_d = FETCH;
`endif
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded at reset.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word address for the read (equals PC).
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- ir_valid  out  1  IR holds an instruction under execution.
- ir  out  32  instruction register.
- opc  out  6  ir[31:26], to the controller.
- func  out  6  ir[5:0], to the controller.
- pc_plus4  out  32  PC+4 of the current instruction, used as the link value.
- ex_done  in  1  datapath retires the current instruction this cycle.
- jmp  in  2  controller jump select: 0 sequential/branch, 1 jump, 2 jump-register, 3 reserved.
- branch_taken  in  1  controller BranchAND.
- jr_target  in  32  register-file value for jump-register.
- misalign_err  out  1  sticky misaligned-target flag.

Function
REQ-003 The FSM SHALL have three states, FETCH, EXEC and HALT; reset SHALL enter FETCH.
REQ-004 In FETCH:
- imem_req=1 and imem_addr=PC.
- imem_req SHALL stay high until imem_ready=1.
- On the cycle with imem_ready=1, ir SHALL capture imem_rdata and the state SHALL become EXEC on the next edge.
REQ-005 Fetch latency SHALL be at least 1 cycle: ir_valid rises the cycle after the imem_ready cycle. Each extra cycle imem_ready stays low adds one cycle.
REQ-006 In EXEC:
- ir_valid=1 and imem_req=0.
- ir, opc and func SHALL be stable until ex_done=1.
- ex_done=0 SHALL hold EXEC indefinitely.
REQ-007 When ex_done=1 in EXEC, PC SHALL load next_pc and the state SHALL become FETCH on the same edge.
REQ-008 next_pc SHALL be selected as follows:
- jmp=2: jr_target.
- jmp=1: {pc_plus4[31:28], ir[25:0], 2'b00}.
- jmp=0 with branch_taken=1: pc_plus4 + (sign_extend(ir[15:0]) << 2).
- Otherwise: pc_plus4.
REQ-009 jmp takes priority over branch_taken. jmp=3 SHALL be treated as sequential.
REQ-010 All PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-011 pc_plus4 SHALL be PC+4, valid in all states.
REQ-012 imem_ready asserted outside FETCH SHALL be ignored.
REQ-013 ex_done asserted outside EXEC SHALL be ignored.
REQ-014 In HALT: imem_req=0, ir_valid=0, PC frozen; the only exit SHALL be reset.

Reset
REQ-015 rst_n low SHALL asynchronously force:
- PC=RESET_PC, state=FETCH.
- ir=0, ir_valid=0, misalign_err=0.
- imem_req=0 while rst_n is low.
REQ-016 Reset asserted mid-fetch or mid-EXEC SHALL discard the in-flight instruction. After rst_n deasserts, the first cycle SHALL request RESET_PC.

Configuration
REQ-017 With macro PC_MISALIGN_CHECK_EN defined:
- A next_pc with bits[1:0]!=0 loaded on ex_done SHALL set misalign_err=1 (sticky) and enter HALT instead of FETCH.
- PC SHALL hold the offending value for debug.
REQ-018 Without PC_MISALIGN_CHECK_EN:
- next_pc[1:0] SHALL be forced to 2'b00.
- misalign_err SHALL be tied 0.
- HALT SHALL be unreachable.

Structure
REQ-019 A shared package mips_pkg SHALL hold:
- the jmp encodings JMP_SEQ=0, JMP_J=1, JMP_JR=2;
- the fetch state enum;
- the field constants OPC_MSB=31, OPC_LSB=26, FUNC_MSB=5.
REQ-020 The next-PC selection (REQ-008 to REQ-010, REQ-018 masking) SHALL be a combinational sub-module pc_next. The FSM and registers SHALL stay in instr_fetch.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release with RESET_PC=0 and imem_ready tied 1 -> imem_addr=0 on the first cycle, ir_valid=1 on the second; on ex_done, imem_addr=4.
- imem_ready held low 3 cycles -> imem_req stays 1 with imem_addr constant; ir_valid rises exactly 1 cycle after imem_ready.
- PC=0x100, ir[15:0]=16'hFFFE, jmp=0, branch_taken=1, ex_done -> next fetch address 0x0FC. Same with branch_taken=0 -> 0x104.
- PC=0x1000_0040, jmp=1, ir[25:0]=26'h0000010 -> next address 0x1000_0040. Same PC with jmp=2, jr_target=0x2000 -> 0x2000. Same PC with jmp=3 -> 0x1000_0044.
- PC_MISALIGN_CHECK_EN defined, jmp=2, jr_target=0x2002 -> misalign_err=1, HALT, imem_req stays 0 for 10+ cycles. Macro undefined -> fetch address 0x2000.
- rst_n pulsed low while in FETCH with imem_ready=0 -> imem_req drops immediately; after release, imem_addr=RESET_PC and ir_valid=0.
